decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, parametrised successor to the mini-MIPS combinational instruction decoder.
- Splits an instruction into opcode, rs, rt, rd, func and imm, sign-extends imm, and classifies the instruction.
- Sits between fetch and register-read, with valid/ready handshakes on both sides and a one-entry skid buffer.
- Adds pipeline flush, a load-use interlock and a retired-decode counter.

Parameters:
- OPCODE_W, 4, opcode field width (MSBs of instruction).
- REG_W, 3, register-address field width (rs, rt, rd).
- FUNC_W, 3, func field width (LSBs of an R-type instruction).
- DATA_W, 16, width of the sign-extended immediate output.
- LOAD_OPCODE, 4'b1000, opcode value treated as a load by the interlock.
- STORE_OPCODE, 4'b1001, opcode value treated as a store; rt is a source.
- CNT_W, 16, width of the decode counter.
- Derived: IMM_W = REG_W+FUNC_W; INSTR_W = OPCODE_W+3*REG_W+FUNC_W (16 at defaults).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held instructions.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  stage accepts in_instr this cycle.
- in_instr  in  INSTR_W  raw instruction.
- out_valid  out  1  decoded fields valid.
- out_ready  in  1  consumer takes the decoded fields this cycle.
- opcode  out  OPCODE_W  instr[INSTR_W-1 -: OPCODE_W].
- rs  out  REG_W  next field below opcode.
- rt  out  REG_W  next field below rs.
- rd  out  REG_W  next field below rt.
- func  out  FUNC_W  instr[FUNC_W-1:0].
- imm  out  DATA_W  instr[IMM_W-1:0] sign-extended.
- is_rtype  out  1  opcode == 0.
- is_load  out  1  opcode == LOAD_OPCODE.
- dest  out  REG_W  rd if is_rtype, else rt.
- writes_reg  out  1  (is_rtype or is_load) and dest != 0.
- hazard  out  1  load-use interlock active this cycle.
- decode_count  out  CNT_W  number of output handshakes since reset.

Behaviour:
- Reset (sync, highest priority): out_valid=0, skid_valid=0, decode_count=0; all field outputs 0.
- Datapath: two registers, OUT (drives the outputs) and SKID. Fields are decoded combinationally from in_instr and captured at acceptance.
- Acceptance: accept = in_valid & in_ready.
- in_ready = !skid_valid & !hazard & !flush.
- Load-use interlock: hazard = in_valid & out_valid & is_load & dest != 0 & (in_rs == dest | (in_uses_rt & in_rt == dest)).
  - in_uses_rt = in opcode == 0 or in opcode == STORE_OPCODE.
  - The dependent instruction waits until the load leaves OUT; this gives at least one bubble.
- Output handshake: fire = out_valid & out_ready.
- Per cycle, when not flushing:
  - If fire or !out_valid, OUT loads from SKID when skid_valid, else from the accepted input.
  - out_valid becomes skid_valid | accept.
  - skid_valid clears when SKID moves to OUT.
  - If accept while out_valid & !out_ready, the input goes to SKID and skid_valid=1.
- Latency: 1 cycle from accept to out_valid when OUT is empty or draining.
- Ordering: strict FIFO. Never drop or duplicate an instruction; at most 2 in flight.
- Outputs are stable while out_valid & !out_ready.
- flush:
  - Next cycle out_valid=0 and skid_valid=0.
  - in_ready=0 during the flush cycle.
  - A fire in the flush cycle still counts; nothing else is accepted.
- decode_count += 1 on every fire; wraps modulo 2^CNT_W.
- Reset asserted mid-transfer discards both entries; reset has priority over flush.

Decomposition:
- Package decode_pkg holds the field-width localparams and the LOAD_OPCODE and STORE_OPCODE defaults.
- The same package holds a decoded-instruction struct/bundle (opcode, rs, rt, rd, func, imm, is_rtype, is_load, dest, writes_reg).
- One sub-module, field_decoder: combinational, instruction to bundle. It is instantiated once on in_instr; OUT and SKID store bundles.

Test Plan:
- Basic R-type:
  - Stimulus: reset, then accept 16'b0000_001_010_011_001 with out_ready=1.
  - Required: next cycle out_valid=1, opcode=0, rs=1, rt=2, rd=3, func=1, is_rtype=1, dest=3, writes_reg=1, decode_count becomes 1 after the fire.
- I-type sign extension:
  - Stimulus: 16'b0100_001_010_111110.
  - Required: imm=16'hFFFE, is_rtype=0, dest=2.
  - Stimulus: imm field 011111.
  - Required: imm=16'h001F.
- Backpressure and skid:
  - Stimulus: out_ready=0, stream instructions A, B, C.
  - Required: A held in OUT, B in SKID, in_ready=0 while C waits. After out_ready=1, outputs are A, B, C in order with no gaps or duplicates; count=3.
- Load-use interlock:
  - Stimulus: load 16'b1000_001_100_000000 (dest 4), then R-type with rs=4.
  - Required: hazard=1 and in_ready=0 for exactly 1 cycle; a bubble appears between the two outputs.
  - Stimulus: same load with rt=0 (dest 0).
  - Required: no hazard.
- Flush and reset mid-operation:
  - Stimulus: fill OUT and SKID, assert flush for 1 cycle.
  - Required: out_valid=0 and skid empty next cycle; count unchanged.
  - Stimulus: reset while full.
  - Required: all outputs 0 and count=0.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 fires.
  - Required: decode_count=1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared field widths, default load/store opcodes and the decoded-instruction
// bundle used by the decode stage and its field decoder.
package decode_pkg;

  localparam int OPCODE_W = 4;
  localparam int REG_W    = 3;
  localparam int FUNC_W   = 3;
  localparam int DATA_W   = 16;
  localparam int IMM_W    = REG_W + FUNC_W;
  localparam int INSTR_W  = OPCODE_W + 3 * REG_W + FUNC_W;

  localparam logic [OPCODE_W-1:0] DEF_LOAD_OPCODE  = 4'b1000;
  localparam logic [OPCODE_W-1:0] DEF_STORE_OPCODE = 4'b1001;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [FUNC_W-1:0]   func;
    logic [DATA_W-1:0]   imm;
    logic                is_rtype;
    logic                is_load;
    logic [REG_W-1:0]    dest;
    logic                writes_reg;
  } decoded_t;

endpackage

// File: rtl/decode_stage_field_decoder.sv
// Combinational split of a raw instruction into its fields plus the
// classification flags the register-read stage needs.
module field_decoder
  import decode_pkg::*;
#(
  parameter logic [OPCODE_W-1:0] LOAD_OPCODE = DEF_LOAD_OPCODE
) (
  input  logic [INSTR_W-1:0] i_instr,
  output decoded_t           o_dec
);

  logic [OPCODE_W-1:0] w_opcode;
  logic [REG_W-1:0]    w_rt;
  logic [REG_W-1:0]    w_rd;
  logic [REG_W-1:0]    w_dest;
  logic                w_isRtype;
  logic                w_isLoad;

  assign w_opcode  = i_instr[INSTR_W-1 -: OPCODE_W];
  assign w_rt      = i_instr[INSTR_W-OPCODE_W-REG_W-1 -: REG_W];
  assign w_rd      = i_instr[INSTR_W-OPCODE_W-2*REG_W-1 -: REG_W];
  assign w_isRtype = (w_opcode == '0);
  assign w_isLoad  = (w_opcode == LOAD_OPCODE);
  // R-type writes rd; every other format names its target in rt.
  assign w_dest    = w_isRtype ? w_rd : w_rt;

  always_comb begin
    o_dec            = '0;
    o_dec.opcode     = w_opcode;
    o_dec.rs         = i_instr[INSTR_W-OPCODE_W-1 -: REG_W];
    o_dec.rt         = w_rt;
    o_dec.rd         = w_rd;
    o_dec.func       = i_instr[FUNC_W-1:0];
    o_dec.imm        = {{(DATA_W-IMM_W){i_instr[IMM_W-1]}}, i_instr[IMM_W-1:0]};
    o_dec.is_rtype   = w_isRtype;
    o_dec.is_load    = w_isLoad;
    o_dec.dest       = w_dest;
    o_dec.writes_reg = (w_isRtype | w_isLoad) & (w_dest != '0);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready on both sides, one-entry skid buffer,
// flush, load-use interlock and a count of decoded instructions handed on.
module decode_stage
  import decode_pkg::*;
#(
  parameter logic [OPCODE_W-1:0] LOAD_OPCODE  = DEF_LOAD_OPCODE,
  parameter logic [OPCODE_W-1:0] STORE_OPCODE = DEF_STORE_OPCODE,
  parameter int                  CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    rd,
  output logic [FUNC_W-1:0]   func,
  output logic [DATA_W-1:0]   imm,
  output logic                is_rtype,
  output logic                is_load,
  output logic [REG_W-1:0]    dest,
  output logic                writes_reg,
  output logic                hazard,
  output logic [CNT_W-1:0]    decode_count
);

  decoded_t         w_in;
  decoded_t         r_out;
  decoded_t         r_skid;
  logic             r_outValid;
  logic             r_skidValid;
  logic [CNT_W-1:0] r_count;
  logic             w_inUsesRt;
  logic             w_hazard;
  logic             w_accept;
  logic             w_fire;

  field_decoder #(.LOAD_OPCODE(LOAD_OPCODE)) u_fieldDecoder (
    .i_instr (in_instr),
    .o_dec   (w_in)
  );

  assign w_inUsesRt = (w_in.opcode == '0) | (w_in.opcode == STORE_OPCODE);

  // Only the instruction in OUT is checked: a load still in SKID already
  // blocks input, and is checked once it advances.
  assign w_hazard = in_valid & r_outValid & r_out.is_load & (r_out.dest != '0) &
                    ((w_in.rs == r_out.dest) | (w_inUsesRt & (w_in.rt == r_out.dest)));

  assign in_ready = ~r_skidValid & ~w_hazard & ~flush;
  assign w_accept = in_valid & in_ready;
  assign w_fire   = r_outValid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_outValid  <= 1'b0;
      r_skidValid <= 1'b0;
      r_count     <= '0;
      r_out       <= '0;
      r_skid      <= '0;
    end else begin
      if (w_fire) begin
        r_count <= r_count + 1'b1;
      end
      if (flush) begin
        r_outValid  <= 1'b0;
        r_skidValid <= 1'b0;
      end else begin
        // SKID and a new acceptance never coincide, since a full SKID drops in_ready.
        if (w_fire || !r_outValid) begin
          r_outValid <= r_skidValid | w_accept;
          if (r_skidValid) begin
            r_out       <= r_skid;
            r_skidValid <= 1'b0;
          end else if (w_accept) begin
            r_out <= w_in;
          end
        end
        if (w_accept && r_outValid && !out_ready) begin
          r_skid      <= w_in;
          r_skidValid <= 1'b1;
        end
      end
    end
  end

  assign out_valid    = r_outValid;
  assign opcode       = r_out.opcode;
  assign rs           = r_out.rs;
  assign rt           = r_out.rt;
  assign rd           = r_out.rd;
  assign func         = r_out.func;
  assign imm          = r_out.imm;
  assign is_rtype     = r_out.is_rtype;
  assign is_load      = r_out.is_load;
  assign dest         = r_out.dest;
  assign writes_reg   = r_out.writes_reg;
  assign hazard       = w_hazard;
  assign decode_count = r_count;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and random checks of decode_stage against a queue-based model
// built from the instruction format and handshake rules.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  opcode;
  logic [2:0]  rs, rt, rd, func, dest;
  logic [15:0] imm;
  logic        is_rtype, is_load, writes_reg, hazard;
  logic [3:0]  decode_count;

  int          total = 0;
  int          bad = 0;
  int          hazCycles = 0;
  int          modelCount = 0;
  logic [15:0] q[$];
  logic [15:0] outLog[$];

  always #5 clk = ~clk;

  decode_stage #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .func(func), .imm(imm),
    .is_rtype(is_rtype), .is_load(is_load), .dest(dest),
    .writes_reg(writes_reg), .hazard(hazard), .decode_count(decode_count)
  );

  // Reference field extraction by plain arithmetic on the 16-bit word.
  function automatic int refOp(input logic [15:0] i);   return int'(i) / 4096;        endfunction
  function automatic int refRs(input logic [15:0] i);   return (int'(i) / 512) % 8;   endfunction
  function automatic int refRt(input logic [15:0] i);   return (int'(i) / 64) % 8;    endfunction
  function automatic int refRd(input logic [15:0] i);   return (int'(i) / 8) % 8;     endfunction
  function automatic int refFunc(input logic [15:0] i); return int'(i) % 8;           endfunction
  function automatic int refImm(input logic [15:0] i);
    int v;
    v = int'(i) % 64;
    return (v >= 32) ? (v - 64 + 65536) : v;
  endfunction
  function automatic int refDest(input logic [15:0] i);
    return (refOp(i) == 0) ? refRd(i) : refRt(i);
  endfunction
  function automatic int refWrites(input logic [15:0] i);
    return ((refOp(i) == 0 || refOp(i) == 8) && refDest(i) != 0) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkFields(input logic [15:0] i);
    checkOutput("opcode", 32'(opcode), 32'(refOp(i)));
    checkOutput("rs", 32'(rs), 32'(refRs(i)));
    checkOutput("rt", 32'(rt), 32'(refRt(i)));
    checkOutput("rd", 32'(rd), 32'(refRd(i)));
    checkOutput("func", 32'(func), 32'(refFunc(i)));
    checkOutput("imm", 32'(imm), 32'(refImm(i)));
    checkOutput("is_rtype", 32'(is_rtype), 32'(refOp(i) == 0));
    checkOutput("is_load", 32'(is_load), 32'(refOp(i) == 8));
    checkOutput("dest", 32'(dest), 32'(refDest(i)));
    checkOutput("writes_reg", 32'(writes_reg), 32'(refWrites(i)));
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic applyStimulus(input logic v, input logic [15:0] ins, input logic ordy, input logic fl);
    logic expHaz, expRdy, expFire, expAcc;
    @(negedge clk);
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
    #1;
    expHaz = 1'b0;
    if (v && q.size() > 0) begin
      if (refOp(q[0]) == 8 && refDest(q[0]) != 0 &&
          (refRs(ins) == refDest(q[0]) ||
           ((refOp(ins) == 0 || refOp(ins) == 9) && refRt(ins) == refDest(q[0]))))
        expHaz = 1'b1;
    end
    expRdy = (q.size() < 2) && !expHaz && !fl;
    checkOutput("hazard", 32'(hazard), 32'(expHaz));
    checkOutput("in_ready", 32'(in_ready), 32'(expRdy));
    checkOutput("out_valid", 32'(out_valid), 32'(q.size() > 0));
    checkOutput("decode_count", 32'(decode_count), 32'(modelCount));
    if (q.size() > 0) checkFields(q[0]);
    if (expHaz) hazCycles++;
    expFire = (q.size() > 0) && ordy;
    expAcc  = v && expRdy;
    if (expFire) begin
      modelCount = (modelCount + 1) % 16;
      outLog.push_back(q[0]);
    end
    if (fl) q.delete();
    else begin
      if (expFire) void'(q.pop_front());
      if (expAcc) q.push_back(ins);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    modelCount = 0;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_count", 32'(decode_count), 32'd0);
    checkOutput("rst_fields", {opcode, rs, rt, rd, func, dest, 1'b0, is_rtype, is_load, writes_reg},
                32'd0);
    checkOutput("rst_imm", 32'(imm), 32'd0);
  endtask

  initial begin
    logic [15:0] instr;
    int          savedCount;
    int          savedHaz;
    int          logBase;

    $display("[TB] start");
    doReset();

    // Basic R-type decode and first fire.
    applyStimulus(1'b1, 16'b0000_001_010_011_001, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("basic_count", 32'(decode_count), 32'd1);

    // Sign extension of the immediate, negative then positive.
    applyStimulus(1'b1, 16'b0100_001_010_111110, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("imm_neg", 32'(imm), 32'h0000_FFFE);
    checkOutput("imm_dest", 32'(dest), 32'd2);
    applyStimulus(1'b1, 16'b0100_001_010_011111, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("imm_pos", 32'(imm), 32'h0000_001F);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    // Backpressure fills OUT then SKID; release drains A, B, C in order.
    doReset();
    logBase = outLog.size();
    applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h3333, 1'b0, 1'b0);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 16'h3333, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h3333, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("bp_order", {outLog[logBase], outLog[logBase+1]}, 32'h1111_2222);
    checkOutput("bp_third", 32'(outLog[logBase+2]), 32'h3333);
    checkOutput("bp_count", 32'(decode_count), 32'd3);

    // Load-use interlock: one stall cycle, then none when the load targets r0.
    savedHaz = hazCycles;
    applyStimulus(1'b1, 16'b1000_001_100_000000, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'b0000_100_000_001_000, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'b0000_100_000_001_000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("lu_haz_cycles", 32'(hazCycles - savedHaz), 32'd1);
    savedHaz = hazCycles;
    applyStimulus(1'b1, 16'b1000_001_000_000000, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'b0000_000_000_001_000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("lu_r0_no_haz", 32'(hazCycles - savedHaz), 32'd0);

    // Flush with both entries held.
    applyStimulus(1'b1, 16'h4444, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
    savedCount = int'(decode_count);
    applyStimulus(1'b1, 16'h6666, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("fl_out_valid", 32'(out_valid), 32'd0);
    checkOutput("fl_skid_empty", 32'(in_ready), 32'd1);
    checkOutput("fl_count", 32'(decode_count), 32'(savedCount));

    // Reset while full.
    applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0888, 1'b0, 1'b0);
    doReset();

    // Counter wrap with a 4-bit counter: 17 fires.
    for (int k = 0; k < 17; k++) applyStimulus(1'b1, 16'(k * 9), 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("wrap_count", 32'(decode_count), 32'd1);

    // Random traffic with frequent loads and occasional flushes.
    for (int k = 0; k < 600; k++) begin
      instr = 16'($urandom);
      if ($urandom_range(0, 2) == 0) instr[15:12] = 4'b1000;
      applyStimulus(1'($urandom_range(0, 3) != 0), instr,
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 30) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
